// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
//   Multi-channel PWM core. One shared counter (edge- or center-aligned) is
//   compared against a per-channel duty value. The counter is paced by a
//   programmable prescaler. PERIOD, DUTY and MODE are double-buffered: the
//   shadow copies are written over the config bus, and the active copies
//   load at each period boundary, or continuously while disabled.
//
// Ports
//   wb_clk_i      system clock
//   wb_rst_ni     asynchronous reset, active low
//   cfg_we_i      one-cycle register write strobe
//   cfg_addr_i    register address (0 CTRL, 1 CHEN, 2 PERIOD, 3+k DUTY[k])
//   cfg_wdata_i   write data
//   cfg_rdata_o   combinational readback of the addressed shadow register
//   pwm_o         registered PWM outputs
//   pwm_oeb_o     registered pad output-enable-bar (0 = driving)
//   period_irq_o  one-cycle pulse per period boundary
module pwm_multi_channel #(
  parameter int NCH     = 15,
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               cfg_we_i,
  input  logic [4:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  output logic [NCH-1:0]     pwm_o,
  output logic [NCH-1:0]     pwm_oeb_o,
  output logic               period_irq_o
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic               en;
  logic               mode;
  logic [PRESC_W-1:0] presc;
  logic [NCH-1:0]     chen;
  logic [WIDTH-1:0]   period_sh;
  logic [WIDTH-1:0]   duty_sh  [NCH];

  logic               mode_act;
  logic [WIDTH-1:0]   period_act;
  logic [WIDTH-1:0]   duty_act [NCH];

  logic [PRESC_W-1:0] pcnt;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;

  logic wr_ctrl, wr_chen, wr_period;
  logic tick, boundary, load_act;
  logic unused_wdata;

  assign wr_ctrl   = cfg_we_i && (cfg_addr_i == 5'd0);
  assign wr_chen   = cfg_we_i && (cfg_addr_i == 5'd1);
  assign wr_period = cfg_we_i && (cfg_addr_i == 5'd2);
  assign unused_wdata = &{1'b0, cfg_wdata_i};

  assign tick = en && (pcnt == presc);

  // A zero period collapses the count to a single value, so every tick ends a period.
  assign boundary = tick && ((period_act == '0) ||
                             (mode_act ? (dir_q == DIR_DOWN && cnt_q == '0)
                                       : (cnt_q == period_act)));

  assign load_act = !en || boundary;

  // Shadow configuration registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      en        <= 1'b0;
      mode      <= 1'b0;
      presc     <= '0;
      chen      <= '0;
      period_sh <= '0;
      for (int k = 0; k < NCH; k++) duty_sh[k] <= '0;
    end else begin
      if (wr_ctrl) begin
        en    <= cfg_wdata_i[0];
        mode  <= cfg_wdata_i[1];
        presc <= cfg_wdata_i[PRESC_W+7:8];
      end
      if (wr_chen)   chen      <= cfg_wdata_i[NCH-1:0];
      if (wr_period) period_sh <= cfg_wdata_i[WIDTH-1:0];
      for (int k = 0; k < NCH; k++)
        if (cfg_we_i && cfg_addr_i == 5'(k + 3)) duty_sh[k] <= cfg_wdata_i[WIDTH-1:0];
    end
  end

  // Active copies sample the shadows before this cycle's writes land, so a
  // write coinciding with a boundary waits for the following boundary.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mode_act   <= 1'b0;
      period_act <= '0;
      for (int k = 0; k < NCH; k++) duty_act[k] <= '0;
    end else if (load_act) begin
      mode_act   <= mode;
      period_act <= period_sh;
      for (int k = 0; k < NCH; k++) duty_act[k] <= duty_sh[k];
    end
  end

  // Prescaler; a PRESC rewrite that lands at or below the running count
  // restarts it without generating a tick.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                                         pcnt <= '0;
    else if (!en || tick)                                   pcnt <= '0;
    else if (wr_ctrl && pcnt >= cfg_wdata_i[PRESC_W+7:8])   pcnt <= '0;
    else                                                    pcnt <= pcnt + 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Counter next state. At a boundary the new mode/period apply: a mode
  // change or an edge-aligned or zero period restarts at 0; otherwise a
  // center-aligned count has just emitted 0 and continues upward from 1.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (boundary) begin
        dir_d = DIR_UP;
        if (mode != mode_act || !mode || period_sh == '0) cnt_d = '0;
        else                                             cnt_d = {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (!mode_act) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == period_act) begin
          cnt_d = cnt_q - 1'b1;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pwm_o        <= '0;
      pwm_oeb_o    <= '1;
      period_irq_o <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) pwm_o[k] <= en && chen[k] && (cnt_q < duty_act[k]);
      pwm_oeb_o    <= ~chen;
      period_irq_o <= boundary;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_addr_i == 5'd0) begin
      cfg_rdata_o[0]           = en;
      cfg_rdata_o[1]           = mode;
      cfg_rdata_o[PRESC_W+7:8] = presc;
    end else if (cfg_addr_i == 5'd1) begin
      cfg_rdata_o[NCH-1:0] = chen;
    end else if (cfg_addr_i == 5'd2) begin
      cfg_rdata_o[WIDTH-1:0] = period_sh;
    end
    for (int k = 0; k < NCH; k++)
      if (cfg_addr_i == 5'(k + 3)) cfg_rdata_o[WIDTH-1:0] = duty_sh[k];
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel
//   Drives the PWM core with directed scenarios followed by random register
//   traffic, comparing every cycle against a phase-based reference model.
module tb_pwm_multi_channel;

  localparam int NCH     = 15;
  localparam int WIDTH   = 16;
  localparam int PRESC_W = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [4:0]      cfg_addr;
  logic [31:0]     cfg_wdata;
  logic [31:0]     cfg_rdata;
  logic [NCH-1:0]  pwm;
  logic [NCH-1:0]  pwm_oeb;
  logic            irq;

  always #5 clk = ~clk;

  pwm_multi_channel #(.NCH(NCH), .WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_rdata_o  (cfg_rdata),
    .pwm_o        (pwm),
    .pwm_oeb_o    (pwm_oeb),
    .period_irq_o (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the position inside a period is a phase index.
  // Edge mode phases 0..P map straight to the count. Center mode phases
  // 1..2P trace up then down; phase 0 is only the fresh start after enable
  // or a mode change. The period ends on the tick at the last phase.
  bit             m_en, m_mode, m_mact;
  int             m_presc, m_pcnt, m_psh, m_pact, m_phase;
  logic [NCH-1:0] m_chen;
  int             m_dsh  [NCH];
  int             m_dact [NCH];
  logic [NCH-1:0] e_pwm, e_oeb;
  logic           e_irq;
  int             hi_cnt [NCH];
  int             irq_cnt;

  function automatic void model_reset();
    m_en = 0; m_mode = 0; m_mact = 0;
    m_presc = 0; m_pcnt = 0; m_psh = 0; m_pact = 0; m_phase = 0;
    m_chen = '0;
    for (int k = 0; k < NCH; k++) begin m_dsh[k] = 0; m_dact[k] = 0; end
    e_pwm = '0; e_oeb = '1; e_irq = 1'b0;
  endfunction

  function automatic void model_load();
    m_pact = m_psh;
    m_mact = m_mode;
    for (int k = 0; k < NCH; k++) m_dact[k] = m_dsh[k];
  endfunction

  function automatic void model_clock(input bit we, input int addr, input logic [31:0] wd);
    bit tick, bnd;
    int cnt, last;
    tick = m_en && (m_pcnt == m_presc);
    if (!m_mact) cnt = m_phase;
    else         cnt = (m_phase <= m_pact) ? m_phase : 2 * m_pact - m_phase;
    last = m_mact ? 2 * m_pact : m_pact;
    bnd  = tick && (m_phase == last);
    for (int k = 0; k < NCH; k++) e_pwm[k] = m_en && m_chen[k] && (cnt < m_dact[k]);
    e_oeb = ~m_chen;
    e_irq = bnd;
    if (!m_en) begin
      m_pcnt = 0; m_phase = 0; model_load();
    end else if (tick) begin
      m_pcnt = 0;
      if (bnd) begin
        m_phase = (m_mode == m_mact && m_mode && m_psh != 0) ? 1 : 0;
        model_load();
      end else begin
        m_phase++;
      end
    end else if (we && addr == 0 && m_pcnt >= int'(wd[15:8])) begin
      m_pcnt = 0;
    end else begin
      m_pcnt++;
    end
    if (we) begin
      if (addr == 0) begin m_en = wd[0]; m_mode = wd[1]; m_presc = int'(wd[15:8]); end
      else if (addr == 1) m_chen = wd[NCH-1:0];
      else if (addr == 2) m_psh = int'(wd[15:0]);
      else if (addr >= 3 && addr < 3 + NCH) m_dsh[addr-3] = int'(wd[15:0]);
    end
  endfunction

  function automatic logic [31:0] model_read(input int addr);
    logic [31:0] v;
    v = '0;
    if (addr == 0) begin v[0] = m_en; v[1] = m_mode; v[15:8] = 8'(m_presc); end
    else if (addr == 1) v[NCH-1:0] = m_chen;
    else if (addr == 2) v = 32'(m_psh);
    else if (addr >= 3 && addr < 3 + NCH) v = 32'(m_dsh[addr-3]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("pwm_o", 32'(pwm), 32'(e_pwm));
    check("pwm_oeb_o", 32'(pwm_oeb), 32'(e_oeb));
    check("period_irq_o", 32'(irq), 32'(e_irq));
  endtask

  task automatic check_read(input int a);
    cfg_addr = a[4:0];
    #1;
    check("cfg_rdata_o", cfg_rdata, model_read(a));
  endtask

  // One clock: drive inputs, step the model with the pre-edge inputs, compare after the edge.
  task automatic apply_stimulus(input bit we, input int addr, input logic [31:0] wd);
    cfg_we = we; cfg_addr = addr[4:0]; cfg_wdata = wd;
    @(posedge clk);
    model_clock(we, addr, wd);
    #1;
    cfg_we = 1'b0;
    check_output();
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 0, 32'h0);
  endtask

  task automatic run_count(input int n);
    for (int k = 0; k < NCH; k++) hi_cnt[k] = 0;
    irq_cnt = 0;
    repeat (n) begin
      apply_stimulus(1'b0, 0, 32'h0);
      for (int k = 0; k < NCH; k++) hi_cnt[k] += int'(pwm[k]);
      irq_cnt += int'(irq);
    end
  endtask

  initial begin
    int          sel, addr;
    logic [31:0] d;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    #12;
    $display("[TB] reset state");
    check_output();
    check_read(0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] edge mode, PERIOD=9 DUTY0=3");
    apply_stimulus(1, 2, 32'd9);
    apply_stimulus(1, 3, 32'd3);
    apply_stimulus(1, 1, 32'h1);
    idle(2);
    apply_stimulus(1, 0, 32'h1);
    idle(12);
    run_count(20);
    check("edge_high_count", 32'(hi_cnt[0]), 32'd6);
    check("edge_irq_count", 32'(irq_cnt), 32'd2);
    check_read(3);

    $display("[TB] mid-period duty write");
    idle(4);
    apply_stimulus(1, 3, 32'hABCD_0007);
    check_read(3);
    idle(25);

    $display("[TB] center mode, PERIOD=4 DUTY0=2");
    apply_stimulus(1, 2, 32'd4);
    apply_stimulus(1, 3, 32'd2);
    apply_stimulus(1, 0, 32'h3);
    idle(40);

    $display("[TB] prescaler 3, PERIOD=1 DUTY0=1");
    apply_stimulus(1, 0, 32'h0);
    apply_stimulus(1, 2, 32'd1);
    apply_stimulus(1, 3, 32'd1);
    idle(2);
    apply_stimulus(1, 0, 32'h0301);
    idle(10);
    run_count(16);
    check("presc_high_count", 32'(hi_cnt[0]), 32'd8);
    check("presc_irq_count", 32'(irq_cnt), 32'd2);

    $display("[TB] duty boundaries, PERIOD=5");
    apply_stimulus(1, 0, 32'h0);
    apply_stimulus(1, 2, 32'd5);
    apply_stimulus(1, 3, 32'd0);
    apply_stimulus(1, 4, 32'd6);
    apply_stimulus(1, 5, 32'd5);
    apply_stimulus(1, 1, 32'h7);
    idle(2);
    apply_stimulus(1, 0, 32'h1);
    idle(8);
    run_count(12);
    check("duty0_zero", 32'(hi_cnt[0]), 32'd0);
    check("duty_over_period", 32'(hi_cnt[1]), 32'd12);
    check("duty_eq_period", 32'(hi_cnt[2]), 32'd10);

    $display("[TB] zero period");
    apply_stimulus(1, 2, 32'd0);
    apply_stimulus(1, 3, 32'd1);
    idle(10);
    run_count(5);
    check("p0_high_count", 32'(hi_cnt[0]), 32'd5);
    check("p0_irq_count", 32'(irq_cnt), 32'd5);

    $display("[TB] random register traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        sel = int'($urandom_range(0, 19));
        addr = (sel < 18) ? sel : 25;
        d = $urandom;
        if (addr == 0) begin
          d[0] = ($urandom_range(0, 7) != 0);
          d[15:8] = 8'($urandom_range(0, 3));
        end else if (addr == 2) begin
          d[15:0] = 16'($urandom_range(0, 12));
        end else if (addr >= 3) begin
          d[15:0] = 16'($urandom_range(0, 14));
        end
        apply_stimulus(1, addr, d);
      end else begin
        apply_stimulus(0, 0, 32'h0);
      end
      if ($urandom_range(0, 4) == 0) check_read(int'($urandom_range(0, 20)));
    end

    $display("[TB] asynchronous reset mid-period");
    apply_stimulus(1, 1, 32'h7FFF);
    apply_stimulus(1, 2, 32'd9);
    apply_stimulus(1, 0, 32'h1);
    idle(6);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pwm", 32'(pwm), 32'h0);
    check("async_oeb", 32'(pwm_oeb), 32'(15'h7FFF));
    check("async_irq", 32'(irq), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
